// File: rtl/iir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// iir_ctrl_pkg
// Shared definitions for the notch-chain coefficient controller:
//   - controller state encoding
//   - bank select encoding (shared by wr_sel and commit_sel)
//   - coefficient count and the passthrough coefficient set
// -----------------------------------------------------------------------------
package iir_ctrl_pkg;

  // Three numerator taps followed by two denominator taps.
  localparam int COEFF_DEPTH = 5;

  localparam logic SEL_1MHZ   = 1'b0;
  localparam logic SEL_2_4MHZ = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    VERIFY,
    SETTLE
  } state_e;

  // Passthrough filter (b0 = 1.0, everything else 0), in units of 1.0.
  // Banks scale these by 2**COEFF_FRAC so the set stays correct for any
  // fixed-point format.
  localparam int DEFAULT_COEFF [COEFF_DEPTH] = '{1, 0, 0, 0, 0};

endpackage

// File: rtl/iir_coeff_bank.sv
// -----------------------------------------------------------------------------
// iir_coeff_bank
// One shadow coefficient bank for a single notch filter.
//   clk, rst   : clock, asynchronous active-high reset (reloads passthrough)
//   wr_en      : write strobe, already qualified by the caller (index valid,
//                bank selected, controller idle)
//   wr_idx     : word index 0..COEFF_DEPTH-1
//   wr_data    : coefficient word
//   rd_words   : all words in parallel, word i at [i*WIDTH +: WIDTH]
//   cmp_words  : readback bus from the filter, same packing as rd_words
//   mismatch   : high when cmp_words differs from the bank in any word
// -----------------------------------------------------------------------------
module iir_coeff_bank
  import iir_ctrl_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int FRAC  = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [2:0]                   wr_idx,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [COEFF_DEPTH*WIDTH-1:0] rd_words,
  input  logic [COEFF_DEPTH*WIDTH-1:0] cmp_words,
  output logic                         mismatch
);

  logic [WIDTH-1:0] words_q [COEFF_DEPTH];
  logic [WIDTH-1:0] words_d [COEFF_DEPTH];

  // NOTE: every combinational output gets a full default before any
  // conditional update, so no path leaves a value held (no latch).
  always_comb begin
    words_d = words_q;
    if (wr_en) begin
      for (int i = 0; i < COEFF_DEPTH; i++) begin
        if (wr_idx == 3'(i)) words_d[i] = wr_data;
      end
    end
  end

  // NOTE: this register array is reset on purpose -- after reset the filter
  // must be able to load a known passthrough set without any prior writes,
  // so it cannot be left to power-up contents like a plain RAM.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COEFF_DEPTH; i++) begin
        words_q[i] <= WIDTH'(DEFAULT_COEFF[i]) << FRAC;
      end
    end else begin
      words_q <= words_d;
    end
  end

  always_comb begin
    rd_words = '0;
    for (int i = 0; i < COEFF_DEPTH; i++) begin
      rd_words[i*WIDTH +: WIDTH] = words_q[i];
    end
  end

  assign mismatch = (rd_words != cmp_words);

endmodule

// File: rtl/iir_coeff_loader.sv
// -----------------------------------------------------------------------------
// iir_coeff_loader
// Run-time coefficient controller for the two-stage notch chain
// (2.4 MHz notch followed by 1 MHz notch).
//   clk, rst            : clock, asynchronous active-high reset
//   valid_in            : chain sample strobe (observed only)
//   wr_*                : word-serial ready/valid coefficient write port
//   commit_*            : ready/valid request to load one bank into its filter
//   bypass_req_*        : user bypass, OR-ed with the forced bypass
//   bypass_*            : bypass to each filter
//   coeff_wr_en_*       : one-cycle load strobe to each filter
//   coeff_in_*          : shadow bank contents, word i at [i*W +: W]
//   coeff_out_*         : readback from each filter, same packing
//   busy, done          : sequence in progress / one-cycle completion pulse
//   verify_err          : sticky readback mismatch of the last commit
//   idx_err             : one-cycle pulse after a write with an invalid index
// A commit forces the target filter into bypass, waits for a cycle without a
// sample, strobes the load, checks the readback, then keeps bypass forced for
// SETTLE_SAMPLES samples while the recursive state settles.
// -----------------------------------------------------------------------------
module iir_coeff_loader
  import iir_ctrl_pkg::*;
#(
  parameter int COEFF_WIDTH    = 20,
  parameter int COEFF_FRAC     = 18,
  parameter int SETTLE_SAMPLES = 8,
  parameter int CNT_WIDTH      = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_in,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic                                 wr_sel,
  input  logic [2:0]                           wr_idx,
  input  logic signed [COEFF_WIDTH-1:0]        wr_data,
  input  logic                                 commit_valid,
  output logic                                 commit_ready,
  input  logic                                 commit_sel,
  input  logic                                 bypass_req_1MHz,
  input  logic                                 bypass_req_2_4MHz,
  output logic                                 bypass_1MHz,
  output logic                                 bypass_2_4MHz,
  output logic                                 coeff_wr_en_1MHz,
  output logic                                 coeff_wr_en_2_4MHz,
  output logic [COEFF_WIDTH*COEFF_DEPTH-1:0]   coeff_in_1MHz,
  output logic [COEFF_WIDTH*COEFF_DEPTH-1:0]   coeff_in_2_4MHz,
  input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0]   coeff_out_1MHz,
  input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0]   coeff_out_2_4MHz,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 verify_err,
  output logic                                 idx_err
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST =
    (SETTLE_SAMPLES > 0) ? CNT_WIDTH'(SETTLE_SAMPLES - 1) : '0;

  state_e               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 force_1_q, force_1_d;
  logic                 force_24_q, force_24_d;
  logic                 wr_en_1_q, wr_en_1_d;
  logic                 wr_en_24_q, wr_en_24_d;
  logic                 done_q, done_d;
  logic                 verify_err_q, verify_err_d;
  logic                 idx_err_q, idx_err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic idle, wr_fire, idx_ok, bank_we_1, bank_we_24;
  logic mismatch_1, mismatch_24, sel_mismatch;

  // Banks only accept writes while idle, so contents are frozen for the
  // whole load/verify window.
  assign idle       = (state_q == IDLE);
  assign wr_fire    = wr_valid & idle;
  assign idx_ok     = (wr_idx < 3'(COEFF_DEPTH));
  assign bank_we_1  = wr_fire & idx_ok & (wr_sel == SEL_1MHZ);
  assign bank_we_24 = wr_fire & idx_ok & (wr_sel == SEL_2_4MHZ);

  iir_coeff_bank #(
    .WIDTH (COEFF_WIDTH),
    .FRAC  (COEFF_FRAC)
  ) u_bank_1mhz (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bank_we_1),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .rd_words  (coeff_in_1MHz),
    .cmp_words (coeff_out_1MHz),
    .mismatch  (mismatch_1)
  );

  iir_coeff_bank #(
    .WIDTH (COEFF_WIDTH),
    .FRAC  (COEFF_FRAC)
  ) u_bank_2_4mhz (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bank_we_24),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .rd_words  (coeff_in_2_4MHz),
    .cmp_words (coeff_out_2_4MHz),
    .mismatch  (mismatch_24)
  );

  assign sel_mismatch = (sel_q == SEL_2_4MHZ) ? mismatch_24 : mismatch_1;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    force_1_d    = force_1_q;
    force_24_d   = force_24_q;
    wr_en_1_d    = 1'b0;
    wr_en_24_d   = 1'b0;
    done_d       = 1'b0;
    verify_err_d = verify_err_q;
    cnt_d        = cnt_q;
    idx_err_d    = wr_fire & ~idx_ok;

    unique case (state_q)
      IDLE: begin
        if (commit_valid) begin
          state_d      = ARM;
          sel_d        = commit_sel;
          verify_err_d = 1'b0;
          cnt_d        = '0;
          force_1_d    = (commit_sel == SEL_1MHZ);
          force_24_d   = (commit_sel == SEL_2_4MHZ);
        end
      end
      ARM: begin
        // Load only in a sample gap; the strobe is registered so it is high
        // for exactly the LOAD cycle.
        if (!valid_in) begin
          state_d    = LOAD;
          wr_en_1_d  = (sel_q == SEL_1MHZ);
          wr_en_24_d = (sel_q == SEL_2_4MHZ);
        end
      end
      LOAD: begin
        state_d = VERIFY;
      end
      VERIFY: begin
        if (sel_mismatch) verify_err_d = 1'b1;
        if (SETTLE_SAMPLES == 0) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          force_1_d  = 1'b0;
          force_24_d = 1'b0;
        end else begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (valid_in) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            force_1_d  = 1'b0;
            force_24_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= SEL_1MHZ;
      force_1_q    <= 1'b0;
      force_24_q   <= 1'b0;
      wr_en_1_q    <= 1'b0;
      wr_en_24_q   <= 1'b0;
      done_q       <= 1'b0;
      verify_err_q <= 1'b0;
      idx_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      force_1_q    <= force_1_d;
      force_24_q   <= force_24_d;
      wr_en_1_q    <= wr_en_1_d;
      wr_en_24_q   <= wr_en_24_d;
      done_q       <= done_d;
      verify_err_q <= verify_err_d;
      idx_err_q    <= idx_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wr_ready           = idle;
  assign commit_ready       = idle;
  assign busy               = ~idle;
  assign done               = done_q;
  assign verify_err         = verify_err_q;
  assign idx_err            = idx_err_q;
  assign coeff_wr_en_1MHz   = wr_en_1_q;
  assign coeff_wr_en_2_4MHz = wr_en_24_q;
  // User bypass requests pass straight through in every state.
  assign bypass_1MHz        = bypass_req_1MHz   | force_1_q;
  assign bypass_2_4MHz      = bypass_req_2_4MHz | force_24_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_iir_coeff_loader
// Self-checking bench for iir_coeff_loader. The reference model is a pair of
// coefficient arrays updated by the write rules, plus the commit timeline
// (ARM, LOAD, VERIFY, SETTLE for a fixed number of samples). A small filter
// model latches coeff_in on coeff_wr_en and can corrupt word 3 on readback.
// -----------------------------------------------------------------------------
module tb_iir_coeff_loader;

  localparam int W     = 20;
  localparam int D     = 5;
  localparam int S     = 8;
  localparam int BUS_W = W * D;
  localparam logic [W-1:0] UNITY = 20'd262144;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic wr_sel = 1'b0;
  logic [2:0] wr_idx = 3'd0;
  logic signed [W-1:0] wr_data = '0;
  logic commit_valid = 1'b0;
  logic commit_ready;
  logic commit_sel = 1'b0;
  logic bypass_req_1MHz = 1'b0;
  logic bypass_req_2_4MHz = 1'b0;
  logic bypass_1MHz, bypass_2_4MHz;
  logic coeff_wr_en_1MHz, coeff_wr_en_2_4MHz;
  logic [BUS_W-1:0] coeff_in_1MHz, coeff_in_2_4MHz;
  logic [BUS_W-1:0] coeff_out_1MHz, coeff_out_2_4MHz;
  logic busy, done, verify_err, idx_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: [0] = 1 MHz bank, [1] = 2.4 MHz bank.
  logic [W-1:0] mbank [2][D];

  // Filter model.
  logic [BUS_W-1:0] filt_1 = '0;
  logic [BUS_W-1:0] filt_24 = '0;
  bit corrupt = 1'b0;
  logic [BUS_W-1:0] w3_mask;

  always #5 clk = ~clk;

  iir_coeff_loader dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_sel             (wr_sel),
    .wr_idx             (wr_idx),
    .wr_data            (wr_data),
    .commit_valid       (commit_valid),
    .commit_ready       (commit_ready),
    .commit_sel         (commit_sel),
    .bypass_req_1MHz    (bypass_req_1MHz),
    .bypass_req_2_4MHz  (bypass_req_2_4MHz),
    .bypass_1MHz        (bypass_1MHz),
    .bypass_2_4MHz      (bypass_2_4MHz),
    .coeff_wr_en_1MHz   (coeff_wr_en_1MHz),
    .coeff_wr_en_2_4MHz (coeff_wr_en_2_4MHz),
    .coeff_in_1MHz      (coeff_in_1MHz),
    .coeff_in_2_4MHz    (coeff_in_2_4MHz),
    .coeff_out_1MHz     (coeff_out_1MHz),
    .coeff_out_2_4MHz   (coeff_out_2_4MHz),
    .busy               (busy),
    .done               (done),
    .verify_err         (verify_err),
    .idx_err            (idx_err)
  );

  always @(posedge clk) begin
    if (coeff_wr_en_1MHz)   filt_1  <= coeff_in_1MHz   ^ (corrupt ? w3_mask : '0);
    if (coeff_wr_en_2_4MHz) filt_24 <= coeff_in_2_4MHz ^ (corrupt ? w3_mask : '0);
  end
  assign coeff_out_1MHz   = filt_1;
  assign coeff_out_2_4MHz = filt_24;

  function automatic logic [BUS_W-1:0] model_bus(input bit s);
    logic [BUS_W-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = mbank[s][i];
    return v;
  endfunction

  function automatic logic [BUS_W-1:0] bus_of(input bit s);
    return s ? coeff_in_2_4MHz : coeff_in_1MHz;
  endfunction

  function automatic logic byp(input bit s);
    return s ? bypass_2_4MHz : bypass_1MHz;
  endfunction

  function automatic logic req(input bit s);
    return s ? bypass_req_2_4MHz : bypass_req_1MHz;
  endfunction

  function automatic logic wen(input bit s);
    return s ? coeff_wr_en_2_4MHz : coeff_wr_en_1MHz;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mbank[s][0] = UNITY;
      for (int i = 1; i < D; i++) mbank[s][i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input bit s, input logic [2:0] idx, input logic [W-1:0] data);
    wr_valid = 1'b1; wr_sel = s; wr_idx = idx; wr_data = data;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready_idle: got %b want 1", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    if (int'(idx) < D) mbank[s][idx] = data;
    checks++;
    if (idx_err !== (int'(idx) >= D)) begin
      errors++; $display("FAIL idx_err idx=%0d: got %b want %b", idx, idx_err, int'(idx) >= D);
    end
    checks++;
    if (bus_of(s) !== model_bus(s) || bus_of(!s) !== model_bus(!s)) begin
      errors++; $display("FAIL write_bank sel=%0d: got %h want %h", s, bus_of(s), model_bus(s));
    end
  endtask

  // Full commit sequence with timeline checks. hold = cycles valid_in stays
  // high in ARM; bad = filter corrupts readback word 3; do_wr = issue a write
  // in the same cycle as the commit.
  task automatic commit_and_check(input bit s, input int hold, input bit bad,
                                  input bit do_wr, input logic [2:0] w_idx,
                                  input logic [W-1:0] w_data);
    int count;
    int guard;
    corrupt = bad;
    commit_sel = s; commit_valid = 1'b1;
    if (do_wr) begin
      wr_valid = 1'b1; wr_sel = s; wr_idx = w_idx; wr_data = w_data;
      if (int'(w_idx) < D) mbank[s][w_idx] = w_data;
    end
    valid_in = (hold > 0);
    tick();
    commit_valid = 1'b0; wr_valid = 1'b0;
    // ARM
    checks++;
    if ({busy, wr_ready, commit_ready, verify_err} !== 4'b1000) begin
      errors++; $display("FAIL arm_flags: busy/wr_ready/commit_ready/verify_err=%b want 1000",
                         {busy, wr_ready, commit_ready, verify_err});
    end
    checks++;
    if (byp(s) !== 1'b1 || byp(!s) !== req(!s)) begin
      errors++; $display("FAIL arm_bypass sel=%0d: got sel=%b other=%b want 1 %b",
                         s, byp(s), byp(!s), req(!s));
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if ({coeff_wr_en_1MHz, coeff_wr_en_2_4MHz} !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL arm_hold cycle %0d: wr_en=%b busy=%b want 00 1",
                           i, {coeff_wr_en_1MHz, coeff_wr_en_2_4MHz}, busy);
      end
      tick();
    end
    valid_in = 1'b0;
    tick();
    // LOAD
    checks++;
    if (wen(s) !== 1'b1 || wen(!s) !== 1'b0) begin
      errors++; $display("FAIL load_wr_en sel=%0d: got sel=%b other=%b want 1 0", s, wen(s), wen(!s));
    end
    checks++;
    if (bus_of(s) !== model_bus(s)) begin
      errors++; $display("FAIL load_coeff sel=%0d: got %h want %h", s, bus_of(s), model_bus(s));
    end
    tick();
    // VERIFY
    checks++;
    if ({coeff_wr_en_1MHz, coeff_wr_en_2_4MHz} !== 2'b00) begin
      errors++; $display("FAIL verify_wr_en: got %b want 00", {coeff_wr_en_1MHz, coeff_wr_en_2_4MHz});
    end
    tick();
    // SETTLE
    checks++;
    if (verify_err !== bad) begin
      errors++; $display("FAIL verify_err: got %b want %b", verify_err, bad);
    end
    // A write attempted while busy must be ignored.
    wr_valid = 1'b1; wr_sel = s; wr_idx = 3'd0; wr_data = W'($urandom);
    count = 0;
    guard = 0;
    while (count < S) begin
      valid_in = (guard > 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || byp(s) !== 1'b1) begin
        errors++; $display("FAIL settle_state count=%0d: done=%b busy=%b bypass=%b want 0 1 1",
                           count, done, busy, byp(s));
      end
      tick();
      wr_valid = 1'b0;
      if (valid_in) count++;
      guard++;
    end
    valid_in = 1'b0;
    checks++;
    if ({done, busy, wr_ready} !== 3'b101) begin
      errors++; $display("FAIL done_pulse: done/busy/wr_ready=%b want 101", {done, busy, wr_ready});
    end
    checks++;
    if (byp(s) !== req(s) || byp(!s) !== req(!s)) begin
      errors++; $display("FAIL bypass_release sel=%0d: got %b %b want %b %b",
                         s, byp(s), byp(!s), req(s), req(!s));
    end
    checks++;
    if (bus_of(s) !== model_bus(s)) begin
      errors++; $display("FAIL bank_frozen sel=%0d: got %h want %h", s, bus_of(s), model_bus(s));
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_width: got %b want 0", done);
    end
    corrupt = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    tick();
    checks++;
    if ({wr_ready, commit_ready, busy, done, verify_err, idx_err,
         coeff_wr_en_1MHz, coeff_wr_en_2_4MHz, bypass_1MHz, bypass_2_4MHz} !== 10'b1100000000) begin
      errors++; $display("FAIL reset_flags: got %b want 1100000000",
                         {wr_ready, commit_ready, busy, done, verify_err, idx_err,
                          coeff_wr_en_1MHz, coeff_wr_en_2_4MHz, bypass_1MHz, bypass_2_4MHz});
    end
    checks++;
    if (coeff_in_1MHz !== model_bus(0) || coeff_in_2_4MHz !== model_bus(1)) begin
      errors++; $display("FAIL reset_banks: got %h %h want %h", coeff_in_1MHz, coeff_in_2_4MHz, model_bus(0));
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_commit();
    logic [W-1:0] vals [D];
    vals = '{W'(1000), W'(-2000), W'(3000), W'(4000), W'(-5000)};
    bypass_req_1MHz = 1'b0; bypass_req_2_4MHz = 1'b0;
    for (int i = 0; i < D; i++) write_word(1'b1, 3'(i), vals[i]);
    commit_and_check(1'b1, 0, 1'b0, 1'b0, 3'd0, '0);
  endtask

  task automatic test_arm_hold();
    for (int i = 0; i < D; i++) write_word(1'b0, 3'(i), W'($urandom));
    commit_and_check(1'b0, 10, 1'b0, 1'b0, 3'd0, '0);
  endtask

  task automatic test_idx_err();
    write_word(1'b0, 3'd5, W'(7));
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL idx_wr_ready: got %b want 1", wr_ready);
    end
    tick();
    checks++;
    if (idx_err !== 1'b0) begin
      errors++; $display("FAIL idx_err_width: got %b want 0", idx_err);
    end
    write_word(1'b1, 3'($urandom_range(5, 7)), W'($urandom));
  endtask

  task automatic test_verify_err();
    bit s;
    s = 1'($urandom);
    write_word(s, 3'd3, W'($urandom));
    commit_and_check(s, $urandom_range(0, 3), 1'b1, 1'b0, 3'd0, '0);
    // verify_err stays set until the next commit is accepted.
    checks++;
    if (verify_err !== 1'b1) begin
      errors++; $display("FAIL verify_err_sticky: got %b want 1", verify_err);
    end
    commit_and_check(s, 0, 1'b0, 1'b0, 3'd0, '0);
  endtask

  task automatic test_write_commit_same();
    bypass_req_1MHz = 1'b1;
    commit_and_check(1'b0, 0, 1'b0, 1'b1, 3'($urandom_range(0, D - 1)), W'($urandom));
    bypass_req_1MHz = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      bit s;
      s = 1'($urandom);
      bypass_req_1MHz   = 1'($urandom);
      bypass_req_2_4MHz = 1'($urandom);
      for (int k = 0; k < 3; k++) write_word(1'($urandom), 3'($urandom_range(0, 7)), W'($urandom));
      commit_and_check(s, $urandom_range(0, 4), 1'($urandom), 1'($urandom),
                       3'($urandom_range(0, 7)), W'($urandom));
    end
    bypass_req_1MHz = 1'b0; bypass_req_2_4MHz = 1'b0;
  endtask

  task automatic test_reset_mid();
    write_word(1'b1, 3'd1, W'($urandom));
    commit_sel = 1'b1; commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    tick(); tick(); tick();
    valid_in = 1'b1;
    tick(); tick();
    valid_in = 1'b0;
    checks++;
    if (busy !== 1'b1 || bypass_2_4MHz !== 1'b1) begin
      errors++; $display("FAIL pre_reset_settle: busy=%b bypass=%b want 1 1", busy, bypass_2_4MHz);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({busy, done, coeff_wr_en_1MHz, coeff_wr_en_2_4MHz, bypass_1MHz, bypass_2_4MHz, wr_ready} !== 7'b0000001) begin
      errors++; $display("FAIL mid_reset_flags: got %b want 0000001",
                         {busy, done, coeff_wr_en_1MHz, coeff_wr_en_2_4MHz, bypass_1MHz, bypass_2_4MHz, wr_ready});
    end
    checks++;
    if (coeff_in_1MHz !== model_bus(0) || coeff_in_2_4MHz !== model_bus(1)) begin
      errors++; $display("FAIL mid_reset_banks: got %h %h want %h", coeff_in_1MHz, coeff_in_2_4MHz, model_bus(1));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'($urandom);
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset cycle %0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    w3_mask = '0;
    w3_mask[3*W] = 1'b1;
    test_reset();
    test_basic_commit();
    test_arm_hold();
    test_idx_err();
    test_verify_err();
    test_write_commit_same();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Run-time coefficient controller for the two-stage notch chain (2.4 MHz notch, then 1 MHz notch).
- Accepts word-serial coefficient writes into per-filter shadow banks through a ready/valid interface.
- On a commit request, forces the target filter into bypass, waits for a sample gap, pulses its coeff_wr_en, reads back coeff_out, then holds bypass for a programmable number of samples so the recursive state settles.

Parameters:
COEFF_WIDTH, 20, coefficient word width (signed)
COEFF_FRAC, 18, coefficient fractional bits
COEFF_DEPTH, 5, coefficients per filter (3 numerator + 2 denominator); fixed
SETTLE_SAMPLES, 8, valid_in pulses during which bypass stays forced after load; 0 = no settle phase
CNT_WIDTH, $clog2(SETTLE_SAMPLES+1), settle counter width; derived

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous reset, active-high
valid_in  in  1  sample strobe of the chain input, observed only
wr_valid  in  1  coefficient write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_sel  in  1  0 = 1 MHz bank, 1 = 2.4 MHz bank
wr_idx  in  3  coefficient index 0..COEFF_DEPTH-1
wr_data  in  COEFF_WIDTH  signed coefficient
commit_valid  in  1  request to load one bank into its filter
commit_ready  out  1  commit accepted when commit_valid & commit_ready
commit_sel  in  1  bank to load, same encoding as wr_sel
bypass_req_1MHz  in  1  user bypass for the 1 MHz notch
bypass_req_2_4MHz  in  1  user bypass for the 2.4 MHz notch
bypass_1MHz  out  1  to filter
bypass_2_4MHz  out  1  to filter
coeff_wr_en_1MHz  out  1  to filter
coeff_wr_en_2_4MHz  out  1  to filter
coeff_in_1MHz  out  COEFF_WIDTH x COEFF_DEPTH  shadow bank 0
coeff_in_2_4MHz  out  COEFF_WIDTH x COEFF_DEPTH  shadow bank 1
coeff_out_1MHz  in  COEFF_WIDTH x COEFF_DEPTH  readback from filter
coeff_out_2_4MHz  in  COEFF_WIDTH x COEFF_DEPTH  readback from filter
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a commit sequence completes
verify_err  out  1  sticky readback mismatch
idx_err  out  1  one-cycle pulse on write with wr_idx >= COEFF_DEPTH

Behaviour:
- Reset: both shadow banks = passthrough (index 0 = 1<<COEFF_FRAC = 262144, others 0); state IDLE; outputs wr_ready=1, commit_ready=1, busy/done/verify_err/idx_err/coeff_wr_en_*=0; forced bypass cleared; settle counter 0.
- coeff_in_* are continuously driven from the shadow registers and never gated.
- wr_ready = commit_ready = (state==IDLE). Banks are frozen outside IDLE.
- Accepted write with a valid index updates bank[wr_sel][wr_idx] on that edge.
- Accepted write with an invalid index is dropped, and idx_err pulses the next cycle.
- Write and commit accepted in the same cycle: the write lands first, and the commit loads the updated bank.
- bypass_X = bypass_req_X | force_X. force_X is set on entry to ARM for the selected filter and cleared on exit from SETTLE (or from VERIFY when SETTLE_SAMPLES=0). The other filter is never forced.
- FSM (sel latched at commit acceptance; verify_err cleared at commit acceptance):
  - IDLE -> ARM on accepted commit.
  - ARM: waits for a cycle with valid_in=0, then goes to LOAD the next cycle. It waits indefinitely; valid_in is observed in the ARM cycle itself.
  - LOAD: coeff_wr_en_sel=1 for exactly one cycle -> VERIFY.
  - VERIFY: compares coeff_out_sel to shadow[sel] across all COEFF_DEPTH words. Any mismatch sets verify_err. -> SETTLE, or -> IDLE with done if SETTLE_SAMPLES=0.
  - SETTLE: counter increments on each valid_in. On count == SETTLE_SAMPLES-1 and valid_in: -> IDLE, done=1 the next cycle, force cleared.
- Latency with valid_in low throughout: commit accepted at edge T, ARM T+1, LOAD T+2, VERIFY T+3, SETTLE from T+4.
- Reset mid-sequence aborts immediately: force cleared, wr_en low, banks revert to passthrough, no done.
- Changes to bypass_req_* are honoured combinationally in every state.

Decomposition:
- Package iir_ctrl_pkg:
  - state enum (IDLE, ARM, LOAD, VERIFY, SETTLE)
  - SEL_1MHZ=1'b0, SEL_2_4MHZ=1'b1
  - COEFF_DEPTH, DEFAULT_COEFF array (passthrough)
- Sub-module iir_coeff_bank: one shadow bank with write port, reset to DEFAULT_COEFF, parallel read, and a mismatch compare against a readback bus. Instantiated twice.

Test Plan:
- Write bank 1 idx0..4 = {1000,-2000,3000,4000,-5000}, commit sel=1, valid_in=0 -> coeff_wr_en_2_4MHz single pulse at T+2; bypass_2_4MHz high T+1 until SETTLE ends; bypass_1MHz stays 0; done after 8 valid_in pulses.
- Commit while valid_in held high 10 cycles -> FSM stays in ARM; LOAD on the first cycle after valid_in drops; no wr_en pulse while valid_in=1.
- Write wr_idx=5 data=7 -> idx_err pulses one cycle; bank contents unchanged; wr_ready stays 1.
- Filter model returns corrupted coeff_out word 3 -> verify_err=1 after VERIFY; sequence still completes with done; next commit clears verify_err.
- rst asserted during SETTLE -> bypass forced low immediately, busy=0, coeff_in_* = {262144,0,0,0,0}, no done pulse.
- Write and commit sel=0 in the same cycle in IDLE; with bypass_req_1MHz=1 -> LOAD drives the new word; bypass_1MHz remains 1 after done.
